puf_eval_sequencer: RTL and testbench
=====================================

// Module: puf_eval_sequencer
// PURPOSE
//  Sequences the on-chip multi-bit PUF for one challenge address. Pulses START,
//  waits for settle, samples the 8-bit response, repeats N_EVAL times, then
//  majority-votes each bit. Returns the voted response plus a per-bit
//  instability mask over a valid/ready pair. Sits between the top-level wrapper
//  I/O and the puf instance; owns the PUF's START and addr inputs.
// PARAMETERS
//  ADDR_W      4  challenge address width (matches puf addr)
//  DATA_W      8  response width (matches puf OUT_reg)
//  N_EVAL      5  evaluations per request; odd, >=1
//  START_CYC   2  cycles puf_start is held high per evaluation, >=1
//  SETTLE_CYC  4  cycles after START falls before sampling, >=1
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  req_valid     in   1       request strobe
//  req_ready     out  1       high only in IDLE
//  req_addr      in   ADDR_W  challenge address, captured on accept
//  rsp_valid     out  1       voted result available
//  rsp_ready     in   1       consumer accepts result
//  rsp_data      out  DATA_W  majority-voted response
//  rsp_unstable  out  DATA_W  bit=1 if that bit was not unanimous over N_EVAL
//  busy          out  1       high from accept until rsp handshake
//  puf_start     out  1       to puf START
//  puf_addr      out  ADDR_W  to puf addr
//  puf_out       in   DATA_W  from puf OUT_reg
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, req_ready=1, rsp_valid=0,
//   rsp_data=0, rsp_unstable=0, busy=0, puf_start=0, puf_addr=0, counters=0.
//   Mid-operation reset aborts; no partial result is ever presented.
//  FSM: IDLE -> ARM -> SETTLE -> SAMPLE -> (ARM | DONE) -> IDLE.
//   IDLE: req_valid&&req_ready accepts; latch req_addr into puf_addr; clear
//    vote counters and eval count; go to ARM.
//   ARM: puf_start=1 for exactly START_CYC cycles.
//   SETTLE: puf_start=0 for exactly SETTLE_CYC cycles.
//   SAMPLE: 1 cycle. Per bit, ones_cnt[i] += puf_out[i]. eval_cnt++.
//    If eval_cnt==N_EVAL-1 before the increment, go to DONE, else go to ARM.
//   DONE: rsp_valid=1; rsp_data/rsp_unstable registered on DONE entry and held
//    stable until rsp_valid&&rsp_ready; then go to IDLE.
//  Vote: ones_cnt width $clog2(N_EVAL+1). data[i] = ones_cnt[i] > N_EVAL/2.
//   unstable[i] = ones_cnt[i]!=0 && ones_cnt[i]!=N_EVAL. No overflow possible.
//  Latency: accept at cycle 0 -> rsp_valid at cycle N_EVAL*(START_CYC+
//   SETTLE_CYC+1)+1 (36 at defaults), with rsp_ready held high.
//  puf_addr is constant from accept through the rsp handshake. puf_start rises
//   exactly N_EVAL times per request.
//  req_ready=0 outside IDLE; req_valid there is ignored, not queued. A new
//   request is accepted no earlier than the cycle after the rsp handshake.
//  busy = !(state==IDLE).
// STRUCTURE
//  Package puf_seq_pkg: state enum (IDLE, ARM, SETTLE, SAMPLE, DONE), the
//   default widths, and a CNT_W function computing $clog2(N_EVAL+1).
//  Sub-module puf_bit_vote: a DATA_W-wide array of ones counters with clear,
//   accumulate and vote/unstable outputs. The FSM and timers stay in the top.
// TESTING
//  1 Stable PUF model returns 0xA5; req addr=3 -> rsp_data=0xA5, unstable=0x00,
//    rsp_valid at cycle 36, puf_addr=3 throughout.
//  2 Model returns 0x01 on evals 0,3,4 and 0x00 on evals 1,2 -> rsp_data=0x01,
//    rsp_unstable=0x01. Flip to 0x01 on only 2 of 5 evals -> rsp_data=0x00.
//  3 Hold rsp_ready=0 for 10 cycles in DONE -> rsp_* stay stable, req_ready=0,
//    extra req_valid is dropped; req_ready=1 the cycle after the handshake.
//  4 Assert rst_n=0 during SETTLE of eval 2 -> outputs take reset values at
//    once. After release, new request completes with correct data.
//  5 Back-to-back sweep addr 0..15 -> 16 responses in order. Exactly 5
//    puf_start rising edges per request, each high exactly 2 cycles.
//  6 N_EVAL=1, START_CYC=1, SETTLE_CYC=1 -> latency 4, rsp_unstable always 0.

Source files
------------

// File: rtl/puf_eval_sequencer_pkg.sv
// Shared types and default geometry for the PUF evaluation sequencer.
package puf_seq_pkg;

  localparam int ADDR_W_DEF     = 4;
  localparam int DATA_W_DEF     = 8;
  localparam int N_EVAL_DEF     = 5;
  localparam int START_CYC_DEF  = 2;
  localparam int SETTLE_CYC_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  // Width able to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/puf_eval_sequencer_if.sv
// Request/response handshake between the wrapper and the PUF sequencer.
interface puf_eval_sequencer_if
  import puf_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] rsp_unstable;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_unstable
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_unstable
  );

endinterface

// File: rtl/puf_eval_sequencer_bit_vote.sv
// Per-bit ones counters with majority vote and unanimity check.
module puf_bit_vote
  import puf_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_EVAL = N_EVAL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              acc,
  input  logic [DATA_W-1:0] bits_in,
  output logic [DATA_W-1:0] vote_data,
  output logic [DATA_W-1:0] vote_unstable
);

  localparam int CNT_W = cnt_w(N_EVAL);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(N_EVAL / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_EVAL);

  logic [CNT_W-1:0] cnt_q [DATA_W];
  logic [CNT_W-1:0] cnt_d [DATA_W];

  // Vote is taken on the next-count value so the final sample is included
  // in the same cycle it is accumulated.
  always_comb begin
    vote_data     = '0;
    vote_unstable = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (acc) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(bits_in[i]);
      end
      vote_data[i]     = (cnt_d[i] > HALF);
      vote_unstable[i] = (cnt_d[i] != '0) && (cnt_d[i] != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_W; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/puf_eval_sequencer.sv
// Drives the PUF START/addr for N_EVAL evaluations of one challenge and
// returns the majority-voted response with a per-bit instability mask.
//
// state  | meaning
// IDLE   | ready for a request
// ARM    | puf_start high, START_CYC cycles
// SETTLE | puf_start low, SETTLE_CYC cycles
// SAMPLE | accumulate puf_out, loop or finish
// DONE   | result held until rsp handshake
module puf_eval_sequencer
  import puf_seq_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int N_EVAL     = N_EVAL_DEF,
  parameter int START_CYC  = START_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  puf_eval_sequencer_if.slave  bus,
  output logic                 busy,
  output logic                 puf_start,
  output logic [ADDR_W-1:0]    puf_addr,
  input  logic [DATA_W-1:0]    puf_out
);

  localparam int CNT_W = cnt_w(N_EVAL);
  localparam int TMR_W = cnt_w((START_CYC > SETTLE_CYC) ? START_CYC : SETTLE_CYC);
  localparam logic [TMR_W-1:0] START_LD  = TMR_W'(START_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_EVAL = CNT_W'(N_EVAL - 1);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  eval_q, eval_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] rsp_unst_q, rsp_unst_d;

  logic              vote_clr, vote_acc;
  logic [DATA_W-1:0] vote_data, vote_unst;

  puf_bit_vote #(
    .DATA_W (DATA_W),
    .N_EVAL (N_EVAL)
  ) u_vote (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (vote_clr),
    .acc           (vote_acc),
    .bits_in       (puf_out),
    .vote_data     (vote_data),
    .vote_unstable (vote_unst)
  );

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    eval_d      = eval_q;
    start_d     = start_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_unst_d  = rsp_unst_q;
    vote_clr    = 1'b0;
    vote_acc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d  = ARM;
          tmr_d    = START_LD;
          eval_d   = '0;
          start_d  = 1'b1;
          addr_d   = bus.req_addr;
          vote_clr = 1'b1;
        end
      end
      ARM: begin
        if (tmr_q == '0) begin
          state_d = SETTLE;
          tmr_d   = SETTLE_LD;
          start_d = 1'b0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      SETTLE: begin
        if (tmr_q == '0) state_d = SAMPLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      SAMPLE: begin
        vote_acc = 1'b1;
        eval_d   = eval_q + CNT_W'(1);
        if (eval_q == LAST_EVAL) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = vote_data;
          rsp_unst_d  = vote_unst;
        end else begin
          state_d = ARM;
          tmr_d   = START_LD;
          start_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      eval_q      <= '0;
      start_q     <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_unst_q  <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      eval_q      <= eval_d;
      start_q     <= start_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_unst_q  <= rsp_unst_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_unstable = rsp_unst_q;
  assign busy             = (state_q != IDLE);
  assign puf_start        = start_q;
  assign puf_addr         = addr_q;

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Scoreboard bench: default sequencer (d=0) and a 1/1/1 build (d=1) against a PUF model.
module tb_puf_eval_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  puf_eval_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus_a ();
  puf_eval_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus_b ();

  logic       req_valid [2];
  logic [3:0] req_addr  [2];
  logic       rsp_ready [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_data  [2];
  logic [7:0] rsp_unst  [2];
  logic       busy      [2];
  logic       puf_start [2];
  logic [3:0] puf_addr  [2];
  logic [7:0] puf_out   [2];

  assign bus_a.req_valid = req_valid[0];
  assign bus_a.req_addr  = req_addr[0];
  assign bus_a.rsp_ready = rsp_ready[0];
  assign req_ready[0]    = bus_a.req_ready;
  assign rsp_valid[0]    = bus_a.rsp_valid;
  assign rsp_data[0]     = bus_a.rsp_data;
  assign rsp_unst[0]     = bus_a.rsp_unstable;

  assign bus_b.req_valid = req_valid[1];
  assign bus_b.req_addr  = req_addr[1];
  assign bus_b.rsp_ready = rsp_ready[1];
  assign req_ready[1]    = bus_b.req_ready;
  assign rsp_valid[1]    = bus_b.rsp_valid;
  assign rsp_data[1]     = bus_b.rsp_data;
  assign rsp_unst[1]     = bus_b.rsp_unstable;

  puf_eval_sequencer #(
    .ADDR_W(4), .DATA_W(8), .N_EVAL(5), .START_CYC(2), .SETTLE_CYC(4)
  ) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_a),
    .busy      (busy[0]),
    .puf_start (puf_start[0]),
    .puf_addr  (puf_addr[0]),
    .puf_out   (puf_out[0])
  );

  puf_eval_sequencer #(
    .ADDR_W(4), .DATA_W(8), .N_EVAL(1), .START_CYC(1), .SETTLE_CYC(1)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_b),
    .busy      (busy[1]),
    .puf_start (puf_start[1]),
    .puf_addr  (puf_addr[1]),
    .puf_out   (puf_out[1])
  );

  function automatic int nev(input int d); return (d != 0) ? 1 : 5;  endfunction
  function automatic int sw (input int d); return (d != 0) ? 1 : 2;  endfunction
  function automatic int lat(input int d); return (d != 0) ? 4 : 36; endfunction

  // PUF model: response for evaluation k is pat[d][k], k counted from START rises.
  logic [7:0] pat [2][5];
  int         base       [2] = '{0, 0};
  int         rise       [2] = '{0, 0};
  int         hi_len     [2] = '{0, 0};
  int         width_err  [2] = '{0, 0};
  int         addr_err   [2] = '{0, 0};
  logic       start_prev [2] = '{1'b0, 1'b0};
  logic [3:0] cur_addr   [2] = '{4'h0, 4'h0};
  int         acc_cyc    [2] = '{0, 0};
  int         cyc = 0;

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      puf_out[d] = 8'h00;
      if (rise[d] > base[d]) puf_out[d] = pat[d][(rise[d] - base[d] - 1) % nev(d)];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (puf_start[d] && !start_prev[d]) rise[d] <= rise[d] + 1;
      if (puf_start[d]) begin
        hi_len[d] <= hi_len[d] + 1;
      end else begin
        if (start_prev[d] && hi_len[d] != sw(d)) width_err[d] <= width_err[d] + 1;
        hi_len[d] <= 0;
      end
      start_prev[d] <= puf_start[d];
      if (busy[d] && puf_addr[d] != cur_addr[d]) addr_err[d] <= addr_err[d] + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] vote_model(input logic [39:0] pats, input int n);
    logic [7:0] dat, uns;
    int ones;
    dat = '0;
    uns = '0;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int e = 0; e < n; e++) ones += int'(pats[8*e + b]);
      dat[b] = (2 * ones > n);
      uns[b] = (ones != 0) && (ones != n);
    end
    return {uns, dat};
  endfunction

  typedef struct {
    int         d;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] unst;
  } exp_t;
  exp_t sb[$];

  // Called and returns at a negedge.
  task automatic send(input int d, input logic [3:0] addr, input logic [39:0] pats, input bit push);
    int to;
    exp_t e;
    logic [15:0] v;
    for (int k = 0; k < 5; k++) pat[d][k] = pats[8*k +: 8];
    base[d]      = rise[d];
    cur_addr[d]  = addr;
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    to = 0;
    while (!req_ready[d] && to < 100) begin
      @(negedge clk);
      to++;
    end
    chk("req_accept_in_time", 32'(to < 100), 1);
    acc_cyc[d] = cyc;
    if (push) begin
      v      = vote_model(pats, nev(d));
      e.d    = d;
      e.addr = addr;
      e.data = v[7:0];
      e.unst = v[15:8];
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic recv(input int d, input int hold);
    int to;
    exp_t e;
    to = 0;
    while (!rsp_valid[d] && to < 200) begin
      @(negedge clk);
      to++;
    end
    if (to >= 200) begin
      chk("rsp_timeout", 0, 1);
      rsp_ready[d] = 1'b1;
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("latency",      32'(cyc - acc_cyc[d]), 32'(lat(d)));
    chk("rsp_data",     32'(rsp_data[d]), 32'(e.data));
    chk("rsp_unstable", 32'(rsp_unst[d]), 32'(e.unst));
    chk("puf_addr",     32'(puf_addr[d]), 32'(e.addr));
    chk("start_rises",  32'(rise[d] - base[d]), 32'(nev(d)));
    chk("req_ready_in_done", 32'(req_ready[d]), 0);
    if (hold > 0) begin
      req_valid[d] = 1'b1;
      req_addr[d]  = ~e.addr;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid",     32'(rsp_valid[d]), 1);
        chk("hold_data",      32'(rsp_data[d]), 32'(e.data));
        chk("hold_unstable",  32'(rsp_unst[d]), 32'(e.unst));
        chk("hold_req_ready", 32'(req_ready[d]), 0);
      end
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
    end
    @(negedge clk);
    chk("rsp_valid_after_hs", 32'(rsp_valid[d]), 0);
    chk("req_ready_after_hs", 32'(req_ready[d]), 1);
    chk("busy_after_hs",      32'(busy[d]), 0);
    if (hold > 0) begin
      @(negedge clk);
      chk("dropped_req_not_taken", 32'(busy[d]), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] p;
    int to;
    req_valid = '{1'b0, 1'b0};
    req_addr  = '{4'h0, 4'h0};
    rsp_ready = '{1'b1, 1'b1};
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 5; k++) pat[d][k] = 8'h00;

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 1);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 0);
      chk("rst_rsp_data",  32'(rsp_data[d]), 0);
      chk("rst_rsp_unst",  32'(rsp_unst[d]), 0);
      chk("rst_busy",      32'(busy[d]), 0);
      chk("rst_puf_start", 32'(puf_start[d]), 0);
      chk("rst_puf_addr",  32'(puf_addr[d]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Stable response
    send(0, 4'd3, {5{8'hA5}}, 1'b1);
    recv(0, 0);

    // Split votes: bit0 set on evals 0,3,4; then on evals 1,3 only
    send(0, 4'd5, {8'h01, 8'h01, 8'h00, 8'h00, 8'h01}, 1'b1);
    recv(0, 0);
    send(0, 4'd6, {8'h00, 8'h01, 8'h00, 8'h01, 8'h00}, 1'b1);
    recv(0, 0);
    send(0, 4'd10, {8'hF0, 8'h0F, 8'hFF, 8'h3C, 8'hC3}, 1'b1);
    recv(0, 0);

    // Back-pressure in DONE with a competing request
    rsp_ready[0] = 1'b0;
    send(0, 4'd9, {8'h81, 8'h7E, 8'h81, 8'h00, 8'hFF}, 1'b1);
    recv(0, 10);

    // Reset during SETTLE of eval 2
    send(0, 4'd7, {5{8'h5A}}, 1'b0);
    to = 0;
    while (!((rise[0] - base[0] == 3) && !puf_start[0] && busy[0]) && to < 100) begin
      @(negedge clk);
      to++;
    end
    chk("reach_settle_eval2", 32'(to < 100), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid[0]), 0);
    chk("abort_req_ready", 32'(req_ready[0]), 1);
    chk("abort_busy",      32'(busy[0]), 0);
    chk("abort_puf_start", 32'(puf_start[0]), 0);
    chk("abort_puf_addr",  32'(puf_addr[0]), 0);
    chk("abort_rsp_data",  32'(rsp_data[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 4'd12, {8'h33, 8'h33, 8'hCC, 8'h33, 8'h33}, 1'b1);
    recv(0, 0);

    // Address sweep with random responses
    for (int a = 0; a < 16; a++) begin
      p = {$urandom, $urandom};
      send(0, 4'(a), p, 1'b1);
      recv(0, 0);
    end

    // Single-evaluation build
    send(1, 4'd2, {32'h0, 8'hA5}, 1'b1);
    recv(1, 0);
    send(1, 4'd15, {32'h0, 8'h3C}, 1'b1);
    recv(1, 0);
    for (int a = 0; a < 4; a++) begin
      p = {$urandom, $urandom};
      send(1, 4'(a + 4), p, 1'b1);
      recv(1, 0);
    end

    for (int d = 0; d < 2; d++) begin
      chk("start_width_err", 32'(width_err[d]), 0);
      chk("puf_addr_moved",  32'(addr_err[d]), 0);
    end
    chk("sb_leftover", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
